// File: rtl/down_counter_borrow_if.sv
// Control/status bundle for one down_counter_borrow stage.
// The slave side is the counter; the master side is whoever loads and enables it.
interface down_counter_borrow_if #(
    parameter int unsigned WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] count;
    logic             bo;
    logic             zero;
    logic             tc;
    logic             expired;

    modport master (
        output load, load_val, en, mode,
        input  count, bo, zero, tc, expired
    );

    modport slave (
        input  load, load_val, en, mode,
        output count, bo, zero, tc, expired
    );
endinterface

// File: rtl/down_counter_borrow.sv
// Loadable, chainable down counter with a combinational borrow-out.
// Stages cascade by feeding one stage's bo into the next stage's en.
// Modes: 0/3 wrap to all-ones, 1 reload from the last loaded value, 2 one-shot (expire at 0).
module down_counter_borrow #(
    parameter int unsigned WIDTH = 4
) (
    input logic                  clk,
    input logic                  rst,
    down_counter_borrow_if.slave bus
);

    localparam logic [0:0] StRun     = 1'b0;
    localparam logic [0:0] StExpired = 1'b1;

    localparam logic [1:0] ModeReload  = 2'd1;
    localparam logic [1:0] ModeOneShot = 2'd2;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             count_zero;
    logic             borrow;

    assign count_zero = (count_q == '0);
    // Borrow is zero-latency so a higher stage decrements on the same edge this one wraps.
    assign borrow     = bus.en & count_zero & (state_q == StRun);

    // Next-state: load beats enable; an expired counter ignores enable entirely.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (bus.load) begin
            count_d  = bus.load_val;
            reload_d = bus.load_val;
            state_d  = StRun;
        end else if (bus.en && (state_q == StRun)) begin
            if (!count_zero) begin
                count_d = count_q - WIDTH'(1);
            end else begin
                tc_d = 1'b1;
                unique case (bus.mode)
                    ModeReload:  count_d = reload_q;
                    ModeOneShot: begin
                        count_d = '0;
                        state_d = StExpired;
                    end
                    default:     count_d = '1;
                endcase
            end
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StRun;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    // Outputs: all registered except bo and zero, which decode registered state.
    always_comb begin
        bus.count   = count_q;
        bus.zero    = count_zero;
        bus.bo      = borrow;
        bus.tc      = tc_q;
        bus.expired = (state_q == StExpired);
    end

endmodule
